// File: rtl/ksz_reg_arbiter_pkg.sv
// Shared constants for the KSZ register-access arbiter: lower-engine state codes,
// requester indices, default hold limit and the arbiter FSM encoding.
package ksz_reg_arbiter_pkg;

  localparam logic [3:0]  LS_WAIT             = 4'b1001;

  localparam int          REQ_INIT            = 0;
  localparam int          REQ_RX              = 1;
  localparam int          REQ_TX              = 2;
  localparam int          NUM_REQ             = 3;

  localparam logic [15:0] TIMEOUT_CYCLES_DFLT = 16'd4096;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ksz_arb_pick.sv
// Winner picker: init has absolute priority; receive/transmit share by round-robin.
// Purely combinational; rr_last=0 prefers receive on a tie, rr_last=1 prefers transmit.
module ksz_arb_pick
  import ksz_reg_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_elig,
  input  logic               rr_last,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    win = '0;
    if (req_elig[REQ_INIT]) begin
      win[REQ_INIT] = 1'b1;
    end else if (req_elig[REQ_RX] && req_elig[REQ_TX]) begin
      if (rr_last) win[REQ_TX] = 1'b1;
      else         win[REQ_RX] = 1'b1;
    end else if (req_elig[REQ_RX]) begin
      win[REQ_RX] = 1'b1;
    end else if (req_elig[REQ_TX]) begin
      win[REQ_TX] = 1'b1;
    end
  end

endmodule

// File: rtl/ksz_reg_arbiter.sv
// Arbitrates three multi-command sequences onto one register-access engine.
// Optional ARB_TIMEOUT_EN bounds ownership to TIMEOUT_CYCLES and masks the evicted holder.
module ksz_reg_arbiter
  import ksz_reg_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [2:0]  req,
  input  logic [23:0] m_offset,
  input  logic [2:0]  m_length,
  input  logic [2:0]  m_WR,
  input  logic [2:0]  m_NewCommand,
  input  logic [2:0]  m_Dummy_Write,
  input  logic [47:0] m_writeData,
  output logic [7:0]  offset,
  output logic        length,
  output logic        WR,
  output logic [15:0] writeData,
  output logic        NewCommand,
  output logic        Dummy_Write,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic        timeout
);

  arb_state_t fsm_q, fsm_d;
  logic [2:0] gnt_q, gnt_d;
  logic       rr_last_q, rr_last_d;
  logic [2:0] elig;
  logic [2:0] win;
  logic       lower_wait;
  logic       own_drop;
  logic       force_rel;

  assign lower_wait = (state == LS_WAIT);
  // Only the holder's own req bit matters once a grant is out.
  assign own_drop   = ((req & gnt_q) == 3'b000);

  ksz_arb_pick u_pick (
    .req_elig (elig),
    .rr_last  (rr_last_q),
    .win      (win)
  );

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]  mask_q, mask_d;
  logic        timeout_q, timeout_d;

  assign elig      = req & ~mask_q;
  assign force_rel = (fsm_q == ARB_OWN) && !own_drop &&
                     (hold_cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    hold_cnt_d = (fsm_q == ARB_OWN) ? hold_cnt_q + 16'd1 : 16'd0;
    mask_d     = (mask_q & req) | (force_rel ? gnt_q : 3'b000);
    timeout_d  = force_rel;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      hold_cnt_q <= 16'd0;
      mask_q     <= 3'b000;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign elig      = req;
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      fsm_q     <= ARB_IDLE;
      gnt_q     <= 3'b000;
      rr_last_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ARB_IDLE:  if (elig != 3'b000 && lower_wait) fsm_d = ARB_OWN;
      ARB_OWN:   if (own_drop || force_rel)        fsm_d = ARB_DRAIN;
      ARB_DRAIN: if (lower_wait)                   fsm_d = ARB_IDLE;
      default:                                     fsm_d = ARB_IDLE;
    endcase
  end

  // Grant is loaded only on the IDLE->OWN edge, so every new grant follows an IDLE cycle.
  always_comb begin
    gnt_d     = 3'b000;
    rr_last_d = rr_last_q;
    if (fsm_d == ARB_OWN) begin
      if (fsm_q == ARB_IDLE) begin
        gnt_d = win;
        if (win[REQ_RX] || win[REQ_TX]) rr_last_d = !rr_last_q;
      end else begin
        gnt_d = gnt_q;
      end
    end
  end

  always_comb begin
    offset      = 8'h00;
    length      = 1'b0;
    WR          = 1'b0;
    writeData   = 16'h0000;
    NewCommand  = 1'b0;
    Dummy_Write = 1'b0;
    if (fsm_q == ARB_OWN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_q[i]) begin
          offset      = offset    | m_offset[8*i +: 8];
          length      = length    | m_length[i];
          WR          = WR        | m_WR[i];
          writeData   = writeData | m_writeData[16*i +: 16];
          NewCommand  = NewCommand  | m_NewCommand[i];
          Dummy_Write = Dummy_Write | m_Dummy_Write[i];
        end
      end
    end
  end

  assign gnt  = gnt_q;
  assign busy = (fsm_q != ARB_IDLE);

endmodule

// File: tb/tb_ksz_reg_arbiter.sv
// Bench for ksz_reg_arbiter: directed vector table, random run against a behavioural
// owner/drain model, and a hold-limit sequence that depends on ARB_TIMEOUT_EN.
module tb_ksz_reg_arbiter;

  localparam logic [15:0] TO = 16'd16;
  localparam logic [3:0]  W  = 4'b1001;
  localparam logic [3:0]  N  = 4'b0000;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [2:0]  req;
  logic [23:0] m_offset;
  logic [2:0]  m_length, m_WR, m_NewCommand, m_Dummy_Write;
  logic [47:0] m_writeData;
  logic [7:0]  offset;
  logic        length, WR, NewCommand, Dummy_Write, busy, timeout;
  logic [15:0] writeData;
  logic [2:0]  gnt;

  int errors = 0;
  int checks = 0;

  always #5 sysclk = ~sysclk;

  ksz_reg_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .sysclk(sysclk), .reset(reset), .state(state), .req(req),
    .m_offset(m_offset), .m_length(m_length), .m_WR(m_WR),
    .m_NewCommand(m_NewCommand), .m_Dummy_Write(m_Dummy_Write),
    .m_writeData(m_writeData), .offset(offset), .length(length), .WR(WR),
    .writeData(writeData), .NewCommand(NewCommand), .Dummy_Write(Dummy_Write),
    .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: who owns the engine, whether we are draining, tie preference.
  int       m_owner;
  bit       m_drain;
  bit       m_tx_pref;
  int       m_hold;
  bit [2:0] m_mask;
  bit       m_pulse;

  task automatic model_step(input bit rst, input bit [2:0] r, input bit wt);
    bit [2:0] el, mnext;
    bit       np;
    if (rst) begin
      m_owner = -1; m_drain = 0; m_tx_pref = 0; m_hold = 0; m_mask = 0; m_pulse = 0;
      return;
    end
    np    = 0;
    mnext = m_mask & r;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_drain = 1;
      end else if (TO_EN && m_hold == int'(TO) - 1) begin
        mnext[m_owner] = 1'b1; np = 1; m_owner = -1; m_drain = 1;
      end else begin
        m_hold++;
      end
    end else if (m_drain) begin
      if (wt) m_drain = 0;
    end else begin
      el = r & ~m_mask;
      if (el != 0 && wt) begin
        if (el[0])                m_owner = 0;
        else if (el[1] && el[2])  m_owner = m_tx_pref ? 2 : 1;
        else                      m_owner = el[1] ? 1 : 2;
        if (m_owner != 0) m_tx_pref = !m_tx_pref;
        m_hold = 0;
      end
    end
    m_mask  = mnext;
    m_pulse = np;
  endtask

  task automatic model_check();
    logic [2:0] eg;
    eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    chk("rnd_gnt",     48'(gnt),     48'(eg));
    chk("rnd_busy",    48'(busy),    48'(m_owner >= 0 || m_drain));
    chk("rnd_timeout", 48'(timeout), 48'(m_pulse));
    if (m_owner >= 0) begin
      chk("rnd_offset", 48'(offset),     48'(m_offset[8*m_owner +: 8]));
      chk("rnd_length", 48'(length),     48'(m_length[m_owner]));
      chk("rnd_wr",     48'(WR),         48'(m_WR[m_owner]));
      chk("rnd_wdata",  48'(writeData),  48'(m_writeData[16*m_owner +: 16]));
      chk("rnd_newcmd", 48'(NewCommand), 48'(m_NewCommand[m_owner]));
      chk("rnd_dummy",  48'(Dummy_Write),48'(m_Dummy_Write[m_owner]));
    end else begin
      chk("rnd_idle_outs", {offset, length, WR, writeData, NewCommand, Dummy_Write}, 48'h0);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  st;
    logic [2:0]  rq;
    logic [2:0]  e_gnt;
    logic        e_busy;
    logic [7:0]  e_off;
    logic        e_wr;
    logic        e_nc;
    logic [15:0] e_wd;
  } vec_t;

  vec_t vecs[19];

  initial begin
    bit       ok;
    int       own_cnt;
    bit [2:0] rq;

    // Fixed bundles: init=0x10/AAAA, rx=0x41/BBBB, tx=0x82/CCCC write
    vecs[0]  = '{1'b0, W, 3'b110, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, N, 3'b010, 3'b010, 1'b1, 8'h41, 1'b0, 1'b1, 16'hBBBB};
    vecs[2]  = '{1'b0, N, 3'b100, 3'b010, 1'b1, 8'h41, 1'b0, 1'b1, 16'hBBBB};
    vecs[3]  = '{1'b0, N, 3'b100, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, W, 3'b100, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, W, 3'b110, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, W, 3'b110, 3'b100, 1'b1, 8'h82, 1'b1, 1'b1, 16'hCCCC};
    vecs[7]  = '{1'b0, W, 3'b010, 3'b100, 1'b1, 8'h82, 1'b1, 1'b1, 16'hCCCC};
    vecs[8]  = '{1'b0, W, 3'b010, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, W, 3'b011, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, W, 3'b011, 3'b001, 1'b1, 8'h10, 1'b0, 1'b1, 16'hAAAA};
    vecs[11] = '{1'b0, W, 3'b010, 3'b001, 1'b1, 8'h10, 1'b0, 1'b1, 16'hAAAA};
    vecs[12] = '{1'b0, W, 3'b010, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, N, 3'b010, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, W, 3'b010, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{1'b0, N, 3'b010, 3'b010, 1'b1, 8'h41, 1'b0, 1'b1, 16'hBBBB};
    vecs[16] = '{1'b1, N, 3'b010, 3'b010, 1'b1, 8'h41, 1'b0, 1'b1, 16'hBBBB};
    vecs[17] = '{1'b0, N, 3'b010, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
    vecs[18] = '{1'b0, W, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};

    reset = 1'b1; state = N; req = 3'b000;
    m_offset = 24'h82_41_10; m_length = 3'b010; m_WR = 3'b100;
    m_NewCommand = 3'b111; m_Dummy_Write = 3'b000; m_writeData = 48'hCCCC_BBBB_AAAA;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    #1;
    chk("reset_gnt",  48'(gnt), 48'h0);
    chk("reset_busy", 48'(busy), 48'h0);
    chk("reset_to",   48'(timeout), 48'h0);
    chk("reset_outs", {offset, length, WR, writeData, NewCommand, Dummy_Write}, 48'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge sysclk);
      reset = vecs[i].rst; state = vecs[i].st; req = vecs[i].rq;
      #1;
      chk($sformatf("vec%0d_gnt", i),    48'(gnt),        48'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_busy", i),   48'(busy),       48'(vecs[i].e_busy));
      chk($sformatf("vec%0d_offset", i), 48'(offset),     48'(vecs[i].e_off));
      chk($sformatf("vec%0d_wr", i),     48'(WR),         48'(vecs[i].e_wr));
      chk($sformatf("vec%0d_newcmd", i), 48'(NewCommand), 48'(vecs[i].e_nc));
      chk($sformatf("vec%0d_wdata", i),  48'(writeData),  48'(vecs[i].e_wd));
      chk($sformatf("vec%0d_timeout", i),48'(timeout),    48'h0);
    end

    // Random run: req bits mostly held, occasional toggles, sporadic reset
    rq = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge sysclk);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      reset         = (c == 0) || ($urandom_range(0, 199) == 0);
      req           = rq;
      state         = ($urandom_range(0, 1) == 0) ? W : 4'($urandom_range(0, 8));
      m_offset      = 24'($urandom);
      m_length      = 3'($urandom);
      m_WR          = 3'($urandom);
      m_NewCommand  = 3'($urandom);
      m_Dummy_Write = 3'($urandom);
      m_writeData   = {16'($urandom), 32'($urandom)};
      #1;
      if (c > 0) model_check();
      @(posedge sysclk);
      model_step(reset, req, state == W);
    end

    // Long ownership by transmit
    @(negedge sysclk);
    reset = 1'b1; req = 3'b000; state = W;
    @(negedge sysclk);
    reset = 1'b0; req = 3'b100;
`ifdef ARB_TIMEOUT_EN
    own_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sysclk); #1;
      if (gnt == 3'b100) own_cnt++;
      else break;
    end
    chk("to_own_cycles", 48'(own_cnt), 48'(TO));
    chk("to_pulse",      48'(timeout), 48'h1);
    chk("to_drain_gnt",  48'(gnt),     48'h0);
    @(negedge sysclk); #1;
    chk("to_pulse_end",  48'(timeout), 48'h0);
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge sysclk); #1;
      if (gnt != 3'b000) ok = 1'b0;
    end
    chk("to_masked_no_regrant", 48'(ok), 48'h1);
    req = 3'b000;
    @(negedge sysclk);
    req = 3'b100;
    ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sysclk); #1;
      if (gnt == 3'b100) begin ok = 1'b1; break; end
    end
    chk("to_regrant_after_toggle", 48'(ok), 48'h1);
`else
    @(negedge sysclk);
    own_cnt = 0;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge sysclk); #1;
      if (gnt == 3'b100) own_cnt++;
      if (timeout !== 1'b0) ok = 1'b0;
    end
    chk("unbounded_own", 48'(own_cnt), 48'd40);
    chk("no_timeout",    48'(ok),      48'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ksz_reg_arbiter.md
KSZ_REG_ARBITER -- requirements
Module: ksz_reg_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd4096: max cycles one requester may hold the grant (used only with the timeout feature).
REQ-002 sysclk  in  1  system clock; the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 state  in  4  lower-level register-access state; Wait = 4'b1001.
REQ-005 req  in  3  sequence request: bit0 init, bit1 receive, bit2 transmit; held high for the whole multi-command sequence.
REQ-006 m_offset  in  24  per-requester offset, 8 bits each, requester i at [8i+7:8i].
REQ-007 m_length, m_WR, m_NewCommand, m_Dummy_Write  in  3 each  per-requester controls, bit i = requester i.
REQ-008 m_writeData  in  48  per-requester write data, requester i at [16i+15:16i].
REQ-009 offset 8, length 1, WR 1, writeData 16, NewCommand 1, Dummy_Write 1  out  muxed controls to the register-access engine.
REQ-010 gnt  out  3  one-hot grant, registered.
REQ-011 busy  out  1  high whenever the FSM is not IDLE.
REQ-012 timeout  out  1  one-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have the states IDLE, OWN and DRAIN.
REQ-014 IDLE: when req!=0 and state==Wait, the FSM SHALL load gnt with the winner and go to OWN at the same edge, so gnt is visible one cycle after the decision.
REQ-015 Priority: req[0] SHALL always win; between req[1] and req[2] the arbiter SHALL round-robin using rr_last (reset value selects receive first) and toggle rr_last on each receive/transmit grant.
REQ-016 OWN: outputs SHALL combinationally follow the granted bundle; in all other states outputs SHALL be 0 (writeData 16'h0000).
REQ-017 OWN→DRAIN SHALL occur when the granted req bit is 0; req changes of ungranted requesters SHALL be ignored.
REQ-018 DRAIN: NewCommand and Dummy_Write SHALL be 0 and gnt SHALL be cleared; DRAIN→IDLE SHALL occur when state==Wait, minimum one DRAIN cycle.
REQ-019 Back-to-back: a new grant SHALL never be issued without at least one IDLE cycle, including when one req drops and another rises in the same cycle.
REQ-020 If state!=Wait in IDLE, pending requests SHALL wait with no grant issued.
REQ-021 gnt SHALL be one-hot or zero at all times.

Reset
REQ-022 On reset SHALL be asserted at a clock edge: FSM→IDLE, gnt=0, busy=0, timeout=0, rr_last=receive, hold counter=0, mask=0; outputs 0 at the next cycle.
REQ-023 Reset mid-OWN SHALL drop the grant without passing through DRAIN.

Configuration
REQ-024 With ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count OWN cycles, clear on entering OWN, and at TIMEOUT_CYCLES-1 force DRAIN, pulse timeout, and set mask[i] for the holder.
REQ-025 A masked requester SHALL be ineligible until its req bit is seen low, which clears mask[i].
REQ-026 Without ARB_TIMEOUT_EN, the counter and mask SHALL be absent, timeout SHALL be tied 0, and ownership SHALL be unbounded.

Structure
REQ-027 Lower-state encodings (Wait etc.), requester indices REQ_INIT=0, REQ_RX=1 and REQ_TX=2, and the default TIMEOUT_CYCLES SHALL live in shared Constants.v.
REQ-028 The priority/round-robin picker SHALL be sub-module ksz_arb_pick (inputs: eligible req, rr_last; output: one-hot winner).

Verification
REQ-029 req=3'b110 with state==Wait → gnt=3'b010 next cycle; after release, req=3'b110 again → gnt=3'b100.
REQ-030 Init held while rx requests: req=3'b011 → gnt=3'b001; rx waits until init drops and DRAIN/IDLE complete.
REQ-031 TX owns with m_offset[23:16]=8'h82, m_WR=1 → offset=8'h82, WR=1; req[2] drops → DRAIN, NewCommand=0, gnt=0.
REQ-032 req[1] falls and req[2] rises in the same cycle, state==Wait → ≥1 DRAIN and 1 IDLE cycle before gnt=3'b100.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: tx holds req → timeout pulse after 16 OWN cycles, no tx re-grant until req[2] toggles low.
REQ-034 reset pulsed during OWN → next cycle gnt=0, NewCommand=0, busy=0.
